// File: rtl/mode_sequencer.sv
// Debounces the mode button, queues accepted presses as a pending toggle and commits it at frame start.
// Press accepted DEBOUNCE_CYCLES+3 edges after a stable button edge; mode/frame_cnt update on the sof edge.
module mode_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic       vsync,
  output logic [1:0] mode,
  output logic       mode_pending,
  output logic       mode_update,
  output logic [7:0] frame_cnt
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_CHK_PRESS = 2'd1;
  localparam logic [1:0] S_HELD      = 2'd2;
  localparam logic [1:0] S_CHK_REL   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_vs_d;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mode;
  logic             r_pending;
  logic             r_update;
  logic [7:0]       r_frame_cnt;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_press;
  logic             w_sof;
  logic             w_btn_s;

  assign w_btn_s = r_sync2;
  assign w_sof   = vsync & ~r_vs_d;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_btn_s) begin
          w_state_nxt = S_CHK_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      S_CHK_PRESS: begin
        if (!w_btn_s) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_HELD;
          w_press     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HELD: begin
        if (!w_btn_s) begin
          w_state_nxt = S_CHK_REL;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        if (w_btn_s) begin
          w_state_nxt = S_HELD;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A press landing on the sof edge is queued for the following frame, never merged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_d      <= 1'b0;
      r_mode      <= 1'b0;
      r_pending   <= 1'b0;
      r_update    <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_vs_d   <= vsync;
      r_update <= w_sof & r_pending;
      if (w_sof) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
        r_mode      <= r_mode ^ r_pending;
        r_pending   <= w_press;
      end else begin
        r_pending <= r_pending ^ w_press;
      end
    end
  end

  assign mode         = {1'b0, r_mode};
  assign mode_pending = r_pending;
  assign mode_update  = r_update;
  assign frame_cnt    = r_frame_cnt;

endmodule

// File: doc/mode_sequencer.md
# mode_sequencer

Control block for the pixel-processing datapath. It debounces the raw mode push-button, queues each accepted press as a pending mode toggle, and commits the toggle only at the start of a frame, so a frame is never shown half in normal and half in grayscale. Its `mode` output drives the select input of the colour/grayscale processing stage. It also provides a frame counter and a one-cycle update strobe to downstream logic.

## Interface

**Parameters**
- `DEBOUNCE_CYCLES`, default 250000: cycles the synchronized button must stay stable to accept a press or release. Legal range is ≥ 2.
- `CNT_W`, default 18: width of the debounce counter. Must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

**Ports**
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`, input, 1: system/pixel clock.
  - `rst`, input, 1: asynchronous, active-high reset.
- `btn_in`, input, 1: raw mode button. Asynchronous, bouncy, active-high.
- `vsync`, input, 1: frame-sync level from the VGA timing generator. Same clock domain, active-high.
- `mode`, output, 2: committed mode. 0 = normal, 1 = grayscale. Values 2 and 3 are never driven.
- `mode_pending`, output, 1: a toggle is queued for the next frame start.
- `mode_update`, output, 1: one-cycle pulse in the cycle after `mode` changes.
- `frame_cnt`, output, 8: count of frame starts since reset. Wraps from 255 to 0.

## Operation

**Reset values**
- `rst` = 1 forces all state immediately, regardless of `clk`:
  - `mode` = 0, `mode_pending` = 0, `mode_update` = 0, `frame_cnt` = 0.
  - Debounce FSM = IDLE, counter = 0, both synchronizer flops = 0, `vs_d` = 0.

**Synchronizer**
- `btn_in` passes through a 2-flop synchronizer; the second flop's output is `btn_s`.
- `btn_in` is never used directly.

**Debounce FSM (4 states)**
- IDLE: if `btn_s`=1, go to CHK_PRESS with cnt=0.
- CHK_PRESS:
  - If `btn_s`=0, return to IDLE. No press is accepted.
  - Else, if cnt = DEBOUNCE_CYCLES−1, go to HELD and generate `press`.
  - Otherwise cnt increments.
- HELD: if `btn_s`=0, go to CHK_REL with cnt=0.
- CHK_REL:
  - If `btn_s`=1, return to HELD.
  - Else, if cnt = DEBOUNCE_CYCLES−1, go to IDLE.
  - Otherwise cnt increments.
- One physical press produces exactly one `press`. Holding the button never repeats.

**Pending queue**
- Each `press` does `mode_pending` <= ~`mode_pending`.
- Two accepted presses within one frame therefore cancel; net result is no change.

**Frame start**
- `vs_d` registers `vsync`. Frame start is `sof` = `vsync` & ~`vs_d`.
- On `sof`:
  - `frame_cnt` increments.
  - If `mode_pending`=1: `mode` <= `mode` ^ 1, `mode_pending` clears, and `mode_update` is 1 in the next cycle.
- `mode_update` = 0 in all other cycles.

**Simultaneous `sof` and `press`**
- The previously queued toggle is committed.
- `mode_pending` is set to 1 (queued for the next frame).
- The new press is never merged into the current frame.

**Other boundaries**
- `vsync` held high: only one `sof` is generated.
- `vsync` already high when reset is released: `sof` is generated on the first cycle after reset.
- `frame_cnt` wrap does not affect mode logic.
- Reset asserted mid-debounce or with a toggle pending: all state is discarded; the press is lost.

## Timing

**Edge numbering**
- Edge 1 is the first `clk` rising edge that samples `btn_in`=1 with the button then stable.
- `btn_s`=1 after edge 2.
- FSM enters CHK_PRESS at edge 3.
- `mode_pending` toggles at edge DEBOUNCE_CYCLES+3.

**Release**
- If `btn_in` falls, FSM returns to IDLE no earlier than DEBOUNCE_CYCLES+3 edges after `btn_in` falls.
- A new press is accepted only from IDLE.

**Commit latency**
- `vsync` sampled 1 at edge N (after 0 at N−1): `mode` and `frame_cnt` update at edge N.
- `mode_update` is high from edge N to N+1.

**Control-path latency**
- `mode` is registered. It changes only at `sof` edges, never mid-frame.
- Worst-case press-to-display latency is one frame plus DEBOUNCE_CYCLES+3 cycles.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4.

- **Reset:** assert `rst` asynchronously mid-cycle → `mode`=0, `mode_pending`=0, `mode_update`=0, `frame_cnt`=0 immediately, without a `clk` edge.
- **Clean press:** `btn_in` high for 20 cycles, then `vsync` pulse → `mode_pending`=1 at edge 7. At the `sof` edge: `mode`=1 and `mode_pending`=0. `mode_update` is high for exactly one cycle.
- **Bounce:** `btn_in` toggles 1,0,1,0 on single cycles, then stays high → exactly one toggle, and no toggle before 7 edges after the last rising bounce. Holding for 100 cycles gives no second toggle.
- **Double press within a frame:** two clean presses separated by release → `mode_pending` goes 1 then 0. At the next `sof`, `mode` is unchanged and `mode_update`=0.
- **Press coincident with `sof`, with a toggle already pending:** `mode` flips at that edge and `mode_pending` stays 1. The next `sof` flips `mode` again.
- **Frame counter:** 257 `vsync` pulses, some held high for several cycles → `frame_cnt`=1 after wrap, with one increment per pulse.
